// File: rtl/light_pkg.sv
// Shared definitions for the light command issuer: key codes, FSM state
// encoding and small sizing/decode helpers.
package light_pkg;

    // Keypad codes that map onto lamp commands
    localparam logic [3:0] KEY_ON  = 4'hA;
    localparam logic [3:0] KEY_OFF = 4'hB;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_RELEASE  = 3'd4
    } light_state_t;

    // Largest of three sizing parameters, used to size the shared counters
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

    // True for codes that produce a lamp command
    function automatic logic is_cmd_key(input logic [3:0] code);
        return (code == KEY_ON) || (code == KEY_OFF);
    endfunction

endpackage

// File: rtl/light_cmd_issuer_key_debounce.sv
// Key stability counter. Tracks the last sampled key level/code and counts
// consecutive unchanged cycles while running. o_stable_valid asserts on the
// cycle whose edge completes DEBOUNCE_CYCLES unchanged cycles.
module key_debounce
    import light_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_run,
    input  logic             i_key_valid,
    input  logic [3:0]       i_key_code,
    output logic             o_stable_valid,
    output logic [3:0]       o_stable_code
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic [3:0]       r_code;
    logic             w_same;

    assign w_same = (i_key_valid == r_valid) && (i_key_code == r_code);

    // Capture the key on clear, restart on any change, else count up and saturate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_code  <= 4'h0;
        end else if (i_clear) begin
            r_cnt   <= '0;
            r_valid <= i_key_valid;
            r_code  <= i_key_code;
        end else if (i_run) begin
            if (!w_same) begin
                r_cnt   <= '0;
                r_valid <= i_key_valid;
                r_code  <= i_key_code;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable_valid = i_run && i_key_valid && w_same && (r_cnt >= CNT_TERM);
    assign o_stable_code  = r_code;

endmodule

// File: rtl/light_cmd_issuer.sv
// Keypad-to-lamp command issuer. Debounces a key, drives a held ON/OFF
// command with a qualify strobe, waits for the lamp acknowledge with a
// timeout, and blocks re-issue until the key is released.
// Optional feature macro: LIGHT_CMD_RETRY_EN (one automatic re-issue on
// the first acknowledge timeout before flagging err).
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no key; debounce tracker follows the inputs
// ST_DEBOUNCE | key seen, waiting for DEBOUNCE_CYCLES unchanged cycles
// ST_ISSUE    | keypad + StartOn/StartOff driven for HOLD_CYCLES cycles
// ST_WAIT_ACK | command lines low, waiting up to ACK_TIMEOUT for lamp_ack
// ST_RELEASE  | command finished or rejected, waiting for key release
module light_cmd_issuer
    import light_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int HOLD_CYCLES     = 4,
    parameter int ACK_TIMEOUT     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       lamp_ack,
    output logic       StartOn,
    output logic       StartOff,
    output logic       keypad,
    output logic       busy,
    output logic       cmd_done,
    output logic       bad_key,
    output logic       err
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, ACK_TIMEOUT)) + 1;

    // Down-counter reload values: terminal count is zero
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LOAD  = CNT_W'(ACK_TIMEOUT - 1);

    light_state_t     r_state;
    logic [CNT_W-1:0] r_tmr;
    logic             r_cmd_on;
    logic             r_start_on;
    logic             r_start_off;
    logic             r_keypad;
    logic             r_busy;
    logic             r_cmd_done;
    logic             r_bad_key;
    logic             r_err;
`ifdef LIGHT_CMD_RETRY_EN
    logic             r_retried;
`endif

    logic             w_deb_clear;
    logic             w_deb_run;
    logic             w_stable_valid;
    logic [3:0]       w_stable_code;
    logic             w_code_on;

    assign w_deb_clear = (r_state == ST_IDLE);
    assign w_deb_run   = (r_state == ST_DEBOUNCE);
    assign w_code_on   = (w_stable_code == KEY_ON);

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key_debounce (
        .clk            (clk),
        .reset          (reset),
        .i_clear        (w_deb_clear),
        .i_run          (w_deb_run),
        .i_key_valid    (key_valid),
        .i_key_code     (key_code),
        .o_stable_valid (w_stable_valid),
        .o_stable_code  (w_stable_code)
    );

    // Sequencing FSM with registered command/status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_tmr       <= '0;
            r_cmd_on    <= 1'b0;
            r_start_on  <= 1'b0;
            r_start_off <= 1'b0;
            r_keypad    <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_done  <= 1'b0;
            r_bad_key   <= 1'b0;
            r_err       <= 1'b0;
`ifdef LIGHT_CMD_RETRY_EN
            r_retried   <= 1'b0;
`endif
        end else begin
            r_cmd_done <= 1'b0;
            r_bad_key  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (key_valid) begin
                        r_state <= ST_DEBOUNCE;
                        r_busy  <= 1'b1;
                    end
                end

                ST_DEBOUNCE: begin
                    if (!key_valid) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_stable_valid) begin
                        if (is_cmd_key(w_stable_code)) begin
                            r_state     <= ST_ISSUE;
                            r_cmd_on    <= w_code_on;
                            r_start_on  <= w_code_on;
                            r_start_off <= !w_code_on;
                            r_keypad    <= 1'b1;
                            r_err       <= 1'b0;
                            r_tmr       <= HOLD_LOAD;
`ifdef LIGHT_CMD_RETRY_EN
                            r_retried   <= 1'b0;
`endif
                        end else begin
                            r_state   <= ST_RELEASE;
                            r_bad_key <= 1'b1;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (r_tmr == '0) begin
                        r_state     <= ST_WAIT_ACK;
                        r_start_on  <= 1'b0;
                        r_start_off <= 1'b0;
                        r_keypad    <= 1'b0;
                        r_tmr       <= ACK_LOAD;
                    end else begin
                        r_tmr <= r_tmr - CNT_W'(1);
                    end
                end

                ST_WAIT_ACK: begin
                    // Acknowledge is checked first so it wins on the expiry cycle
                    if (lamp_ack) begin
                        r_state    <= ST_RELEASE;
                        r_cmd_done <= 1'b1;
                        r_tmr      <= '0;
                    end else if (r_tmr == '0) begin
`ifdef LIGHT_CMD_RETRY_EN
                        if (!r_retried) begin
                            r_state     <= ST_ISSUE;
                            r_retried   <= 1'b1;
                            r_start_on  <= r_cmd_on;
                            r_start_off <= !r_cmd_on;
                            r_keypad    <= 1'b1;
                            r_err       <= 1'b0;
                            r_tmr       <= HOLD_LOAD;
                        end else begin
                            r_state <= ST_RELEASE;
                            r_err   <= 1'b1;
                        end
`else
                        r_state <= ST_RELEASE;
                        r_err   <= 1'b1;
`endif
                    end else begin
                        r_tmr <= r_tmr - CNT_W'(1);
                    end
                end

                ST_RELEASE: begin
                    if (!key_valid) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_tmr       <= '0;
                    r_start_on  <= 1'b0;
                    r_start_off <= 1'b0;
                    r_keypad    <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign StartOn  = r_start_on;
    assign StartOff = r_start_off;
    assign keypad   = r_keypad;
    assign busy     = r_busy;
    assign cmd_done = r_cmd_done;
    assign bad_key  = r_bad_key;
    assign err      = r_err;

endmodule

// File: doc/light_cmd_issuer.md
LIGHT_CMD_ISSUER -- requirements
Module: light_cmd_issuer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 8: consecutive stable cycles required to accept a key.
REQ-002 Parameter HOLD_CYCLES, default 4: cycles a command is driven onto StartOn/StartOff/keypad.
REQ-003 Parameter ACK_TIMEOUT, default 16: maximum cycles to wait for lamp_ack.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 key_valid  input  1  raw key-pressed level from the keypad scanner.
REQ-007 key_code  input  4  raw key code; 4'hA = ON, 4'hB = OFF.
REQ-008 lamp_ack  input  1  completion level from the lamp controller.
REQ-009 StartOn  output  1  ON command level to the lamp controller.
REQ-010 StartOff  output  1  OFF command level to the lamp controller.
REQ-011 keypad  output  1  command-qualify strobe to the lamp controller.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 cmd_done  output  1  one-cycle pulse on acknowledged command.
REQ-014 bad_key  output  1  one-cycle pulse on debounced unsupported code.
REQ-015 err  output  1  sticky acknowledge-timeout flag.

Function
REQ-016 The block SHALL implement states IDLE, DEBOUNCE, ISSUE, WAIT_ACK and RELEASE.
REQ-017 IDLE -> DEBOUNCE when key_valid=1, with the stability counter cleared.
REQ-018 In DEBOUNCE, any change in key_valid or key_code SHALL clear the counter, and key_valid=0 SHALL return the block to IDLE.
REQ-019 After DEBOUNCE_CYCLES stable cycles, code 4'hA or 4'hB SHALL move the block to ISSUE and latch the command; any other code SHALL pulse bad_key and go to RELEASE.
REQ-020 ISSUE SHALL drive keypad=1 plus exactly one of StartOn/StartOff for exactly HOLD_CYCLES cycles, starting the cycle after acceptance, and SHALL then go to WAIT_ACK.
REQ-021 Entry to ISSUE SHALL clear err.
REQ-022 In WAIT_ACK, keypad, StartOn and StartOff SHALL be 0, and lamp_ack=1 SHALL pulse cmd_done and go to RELEASE.
REQ-023 If lamp_ack is not seen within ACK_TIMEOUT cycles of WAIT_ACK entry, the block SHALL set err and go to RELEASE.
REQ-024 If lamp_ack=1 arrives on the expiry cycle, the acknowledge SHALL win and err SHALL stay 0.
REQ-025 lamp_ack SHALL be ignored outside WAIT_ACK.
REQ-026 RELEASE SHALL wait for key_valid=0 before going to IDLE, so a held key issues only one command.
REQ-027 Counters SHALL saturate and never wrap; widths SHALL be sized with $clog2 of the largest parameter plus 1.

Reset
REQ-028 Asserting reset SHALL immediately force state IDLE, all counters to 0, and StartOn, StartOff, keypad, busy, cmd_done, bad_key and err to 0, including mid-ISSUE.
REQ-029 After reset deassertion, a key already held SHALL restart debounce from zero.

Configuration
REQ-030 With LIGHT_CMD_RETRY_EN defined, the first timeout of a command SHALL re-enter ISSUE once with the same command, and err SHALL be set only on the second timeout.
REQ-031 Without LIGHT_CMD_RETRY_EN, the first timeout SHALL set err directly.

Structure
REQ-032 Package light_pkg SHALL hold the key-code constants KEY_ON and KEY_OFF and the state enumeration.
REQ-033 The debounce counter SHALL be the sub-module key_debounce, which outputs a stable valid and code.

Verification
REQ-034 key_valid=1 with code 4'hA held for 20 cycles, lamp_ack 3 cycles after ISSUE ends -> StartOn=keypad=1 for 4 cycles, cmd_done pulses once, no second command.
REQ-035 Code 4'hB with key_valid glitching low at debounce cycle 5 -> no command; a clean 8-cycle hold then issues StartOff.
REQ-036 Code 4'h3 held 8 cycles -> bad_key pulses once, outputs stay 0, busy until release.
REQ-037 Code 4'hA with lamp_ack never asserted -> err=1 after 16 WAIT_ACK cycles (after 2 issues with LIGHT_CMD_RETRY_EN).
REQ-038 lamp_ack asserted exactly on timeout cycle 16 -> cmd_done=1, err=0.
REQ-039 reset pulsed during ISSUE cycle 2 -> all outputs 0 on the same edge and state IDLE.
